wb_line_port: RTL and testbench
===============================

// Module: wb_line_port
// PURPOSE
//  Parametrised CPU-side Wishbone master port: converts word-granular pipeline
//  read/write requests into single line-wide Wishbone transfers to a cache.
//  Generalises the fixed 16b-word / 128b-line icache/dcache hookup in the
//  lc3b cpu top. Adds registered request hold, bus timeout with error
//  response, and an optional last-line read buffer.
//  One instance per cache port (I-side: writes tied 0; D-side: full use).
// PARAMETERS
//  ADDR_W   16   byte address width
//  WORD_W   16   CPU word width (multiple of 8)
//  LINE_W   128  Wishbone data/line width (power-of-2 multiple of WORD_W)
//  TIMEOUT  64   bus cycles before forced error; 0 = no timeout
//  Derived: BE_W=WORD_W/8, SEL_W=LINE_W/8, OFS_W=log2(SEL_W), WIX_W=log2(LINE_W/WORD_W)
// PORTS
//  clk        in   1             clock
//  rst_n      in   1             async active-low reset
//  req_read   in   1             read request (held until resp)
//  req_write  in   1             write request (held until resp); wins over read
//  req_addr   in   ADDR_W        byte address; bit log2(BE_W)-1:0 ignored
//  req_wdata  in   WORD_W        write data
//  req_be     in   BE_W          write byte enables
//  resp       out  1             1-cycle completion pulse
//  resp_err   out  1             valid with resp: bus error/timeout
//  rdata      out  WORD_W        read word, valid with resp
//  busy       out  1             state != IDLE
//  wb_adr     out  ADDR_W-OFS_W  line address = addr[ADDR_W-1:OFS_W]
//  wb_dat_m   out  LINE_W        {LINE_W/WORD_W{wdata}}
//  wb_dat_s   in   LINE_W        read line
//  wb_stb     out  1             strobe; wb_cyc = wb_stb
//  wb_cyc     out  1             cycle
//  wb_we      out  1             write enable
//  wb_sel     out  SEL_W         write: be << (wix*BE_W); read: all ones
//  wb_ack     in   1             transfer ack
//  wb_err     in   1             transfer error
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE; wb_stb/wb_cyc/wb_we/resp/resp_err 0;
//    wb_sel 0; wb_adr, wb_dat_m, rdata 0; timeout counter 0; buffer invalid.
//  - States: IDLE, BUS, HIT, DONE.
//  - IDLE: req_read|req_write at edge t -> latch addr/wdata/be/we; -> BUS
//    (or HIT, buffer feature). wb_stb=1 from t+1; all wb_* outputs registered,
//    stable until termination.
//  - BUS: wb_ack or wb_err terminates; wb_ack wins if both. Timeout counter
//    increments each BUS cycle; reaching TIMEOUT terminates as error.
//    Termination at edge t+k: wb_stb drops; rdata <= wb_dat_s word[wix];
//    resp_err <= err; -> DONE.
//  - DONE: resp=1 exactly one cycle (t+k+1); -> IDLE. Requests in DONE
//    ignored. Min latency request->resp = 2 cycles (ack in first BUS cycle).
//  - IDLE after DONE re-accepts any held request; CPU must drop req in the
//    resp cycle.
//  - wix = addr[OFS_W-1:log2(BE_W)]; wrap n/a (one line per transfer, no
//    crossing).
//  - Read: wb_we=0, wb_sel all ones. Write with req_be=0: still issues bus
//    cycle, wb_sel=0.
//  - Reset mid-BUS: wb_stb drops asynchronously; no resp generated.
// CONFIGURATION
//  WB_LINE_PORT_RDBUF_EN defined: one-line buffer (tag+line+valid).
//   - Filled on error-free read ack.
//   - IDLE read whose addr[ADDR_W-1:OFS_W] matches valid tag -> HIT
//     (no bus cycle), rdata from buffer, resp next cycle (1-cycle latency).
//   - Write to buffered line: bytes merged into buffer on error-free ack;
//     write error invalidates.
//  Undefined: no buffer, no HIT state; every read uses the bus.
// TESTING
//  - Read addr 16'h1236, wb_dat_s word3=16'hBEEF, ack 1st BUS cycle ->
//    wb_adr=12'h123, resp at t+2, rdata=16'hBEEF, resp_err=0.
//  - Write addr 16'h0A04, wdata 16'h55AA, be 2'b01 -> wb_we=1,
//    wb_sel=16'h0010, wb_dat_m=8x16'h55AA, resp after ack.
//  - TIMEOUT=4, no ack -> wb_stb high 4 cycles, drops; resp=1 with resp_err=1.
//  - Read + write asserted together, addr 16'h0002 -> write issued
//    (wb_we=1); wb_err with wb_ack -> resp_err=0.
//  - rst_n low while wb_stb=1 -> wb_stb=0 same cycle, no resp; post-reset
//    read works.
//  - RDBUF_EN: read 16'h2000 then 16'h200E -> 2nd: no wb_stb, resp next
//    cycle, word7 of 1st line.

Source files
------------

// File: rtl/wb_line_port.sv
// -----------------------------------------------------------------------------
// wb_line_port
//   CPU-side Wishbone master port. Turns a held word-granular read/write
//   request into one line-wide Wishbone transfer. The request is latched
//   on acceptance, so every wb_* output is registered and stays stable
//   for the whole bus cycle. A bus timeout ends the transfer with an
//   error response.
//
//   Optional feature (define WB_LINE_PORT_RDBUF_EN): a one-line read
//   buffer (tag + line + valid). A read that hits the buffer completes
//   without a bus cycle. Writes to the buffered line merge their bytes on
//   an error-free ack. A write error on that line invalidates it.
//   Without the macro, every read uses the bus.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_read/req_write   held requests; write wins when both are asserted
//   req_addr             byte address (the byte-in-word bits are ignored)
//   req_wdata, req_be    write word and its byte enables
//   resp, resp_err       one-cycle completion pulse and its error flag
//   rdata                read word, valid with resp
//   busy                 port is not idle
//   wb_adr               line address, wb_dat_m replicated write word
//   wb_dat_s             read line
//   wb_stb/wb_cyc/wb_we  Wishbone master controls
//   wb_sel               Wishbone byte selects
//   wb_ack, wb_err       slave terminations
// -----------------------------------------------------------------------------
module wb_line_port #(
    parameter int ADDR_W  = 16,
    parameter int WORD_W  = 16,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 64
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_read,
    input  logic                                 req_write,
    input  logic [ADDR_W-1:0]                    req_addr,
    input  logic [WORD_W-1:0]                    req_wdata,
    input  logic [WORD_W/8-1:0]                  req_be,
    output logic                                 resp,
    output logic                                 resp_err,
    output logic [WORD_W-1:0]                    rdata,
    output logic                                 busy,
    output logic [ADDR_W-$clog2(LINE_W/8)-1:0]   wb_adr,
    output logic [LINE_W-1:0]                    wb_dat_m,
    input  logic [LINE_W-1:0]                    wb_dat_s,
    output logic                                 wb_stb,
    output logic                                 wb_cyc,
    output logic                                 wb_we,
    output logic [LINE_W/8-1:0]                  wb_sel,
    input  logic                                 wb_ack,
    input  logic                                 wb_err
);

    localparam int BE_W  = WORD_W / 8;
    localparam int SEL_W = LINE_W / 8;
    localparam int OFS_W = $clog2(SEL_W);
    localparam int NWORD = LINE_W / WORD_W;
    localparam int WIX_W = (NWORD > 1) ? $clog2(NWORD) : 1;
    localparam int BOFS  = $clog2(BE_W);
    localparam int TAG_W = ADDR_W - OFS_W;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2,
        HIT  = 2'd3
    } state_t;

    state_t             state;
    logic [WIX_W-1:0]   wix_q;
    logic [TO_W-1:0]    tcnt;

    logic [WIX_W-1:0]   wix_in;
    logic [SEL_W-1:0]   sel_wr;
    logic [WORD_W-1:0]  rd_word;
    logic               timeout_hit;
    logic               bus_end;

    // The byte-in-word address bits carry no meaning for this port.
    logic unused_addr;
    assign unused_addr = ^req_addr;

    assign wix_in      = req_addr[BOFS +: WIX_W];
    assign sel_wr      = {{(SEL_W-BE_W){1'b0}}, req_be} << (wix_in * BE_W);
    assign rd_word     = wb_dat_s[wix_q * WORD_W +: WORD_W];
    assign timeout_hit = (TIMEOUT != 0) && (tcnt == TO_W'(TIMEOUT - 1));
    assign bus_end     = (state == BUS) && (wb_ack || wb_err || timeout_hit);

    assign wb_cyc = wb_stb;
    assign busy   = (state != IDLE);

`ifdef WB_LINE_PORT_RDBUF_EN
    logic               buf_valid;
    logic [TAG_W-1:0]   buf_tag;
    logic [LINE_W-1:0]  buf_line;
    logic [LINE_W-1:0]  merged_line;
    logic               rd_hit;
    logic               buf_same_line;

    assign rd_hit        = req_read && !req_write && buf_valid &&
                           (req_addr[ADDR_W-1:OFS_W] == buf_tag);
    assign buf_same_line = buf_valid && (wb_adr == buf_tag);

    // NOTE: always_comb starts from a full default so no path leaves a
    // bit unassigned, which would otherwise infer a latch.
    always_comb begin
        merged_line = buf_line;
        for (int b = 0; b < SEL_W; b++) begin
            if (wb_sel[b]) merged_line[b*8 +: 8] = wb_dat_m[b*8 +: 8];
        end
    end

    // NOTE: the buffer payload has no reset; the valid bit (reset below)
    // guards it, which keeps the wide data path free of reset routing.
    always_ff @(posedge clk) begin
        if (bus_end && wb_ack && !wb_we) begin
            buf_tag  <= wb_adr;
            buf_line <= wb_dat_s;
        end else if (bus_end && wb_ack && wb_we && buf_same_line) begin
            buf_line <= merged_line;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
        end else if (bus_end && wb_ack && !wb_we) begin
            buf_valid <= 1'b1;
        end else if (bus_end && !wb_ack && wb_we && buf_same_line) begin
            buf_valid <= 1'b0;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_sel   <= '0;
            wb_adr   <= '0;
            wb_dat_m <= '0;
            rdata    <= '0;
            resp     <= 1'b0;
            resp_err <= 1'b0;
            wix_q    <= '0;
            tcnt     <= '0;
        end else begin
            resp <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_read || req_write) begin
                        wb_adr   <= req_addr[ADDR_W-1:OFS_W];
                        wix_q    <= wix_in;
                        resp_err <= 1'b0;
`ifdef WB_LINE_PORT_RDBUF_EN
                        if (rd_hit) begin
                            rdata <= buf_line[wix_in * WORD_W +: WORD_W];
                            resp  <= 1'b1;
                            state <= HIT;
                        end else
`endif
                        begin
                            wb_stb   <= 1'b1;
                            wb_we    <= req_write;
                            wb_sel   <= req_write ? sel_wr : '1;
                            wb_dat_m <= {NWORD{req_wdata}};
                            tcnt     <= '0;
                            state    <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (TIMEOUT != 0) tcnt <= tcnt + 1'b1;
                    if (bus_end) begin
                        wb_stb   <= 1'b0;
                        rdata    <= rd_word;
                        resp_err <= !wb_ack;   // ack wins over err
                        resp     <= 1'b1;
                        state    <= DONE;
                    end
                end
                // The resp cycle: held requests are ignored here.
                DONE:    state <= IDLE;
                HIT:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_line_port.sv
// -----------------------------------------------------------------------------
// tb_wb_line_port
//   Directed bench for wb_line_port (TIMEOUT = 4). Stimulus pushes the
//   expected {resp_err, rdata} of each transfer into a scoreboard queue.
//   A monitor pops and compares on every resp pulse. Bus-side outputs are
//   checked inline while each transfer is open.
// -----------------------------------------------------------------------------
module tb_wb_line_port;

    logic         clk;
    logic         rst_n;
    logic         req_read, req_write;
    logic [15:0]  req_addr, req_wdata;
    logic [1:0]   req_be;
    logic         resp, resp_err, busy;
    logic [15:0]  rdata;
    logic [11:0]  wb_adr;
    logic [127:0] wb_dat_m, wb_dat_s;
    logic         wb_stb, wb_cyc, wb_we, wb_ack, wb_err;
    logic [15:0]  wb_sel;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [16:0] sb[$];

    localparam logic [127:0] L1  = 128'h7777_6666_5555_4444_BEEF_2222_1111_0000;
    localparam logic [127:0] L2  = 128'h7077_6066_5055_4044_3033_2022_1011_0000;
    localparam logic [127:0] L2M = 128'h7077_6066_5055_4044_3033_A522_1011_0000;
    localparam logic [127:0] L3  = 128'h9999_8888_7777_6666_5555_4444_C0DE_2222;

    wb_line_port #(
        .ADDR_W(16), .WORD_W(16), .LINE_W(128), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .resp(resp), .resp_err(resp_err), .rdata(rdata), .busy(busy),
        .wb_adr(wb_adr), .wb_dat_m(wb_dat_m), .wb_dat_s(wb_dat_s),
        .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_we(wb_we), .wb_sel(wb_sel),
        .wb_ack(wb_ack), .wb_err(wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every resp pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && resp) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 1'b1, 1'b0);
            end else begin
                logic [16:0] e;
                e = sb.pop_front();
                check("resp_err", resp_err, e[16]);
                check("rdata", rdata, e[15:0]);
            end
        end
    end

    // One bus transfer: termination (ack/err as given, or timeout) lands on
    // the edge ending the cycles-th strobe cycle.
    task automatic run_txn(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [1:0] be,
                           input logic [127:0] line, input int cycles,
                           input logic ack, input logic err,
                           input logic exp_err, input logic [15:0] exp_word,
                           input logic [11:0] exp_adr, input logic exp_we,
                           input logic [15:0] exp_sel);
        sb.push_back({exp_err, exp_word});
        @(negedge clk);
        req_read = rd; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("wb_stb_open", wb_stb, 1'b1);
            if (i == 0) begin
                check("wb_cyc", wb_cyc, 1'b1);
                check("wb_adr", wb_adr, exp_adr);
                check("wb_we", wb_we, exp_we);
                check("wb_sel", wb_sel, exp_sel);
                check("wb_dat_m", wb_dat_m, {8{wdata}});
                check("busy", busy, 1'b1);
            end
            if (i == cycles - 1) begin
                wb_ack = ack; wb_err = err; wb_dat_s = line;
            end
            @(posedge clk);
        end
        @(negedge clk);
        check("resp_latency", resp, 1'b1);
        check("wb_stb_closed", wb_stb, 1'b0);
        req_read = 1'b0; req_write = 1'b0; wb_ack = 1'b0; wb_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("resp_one_cycle", resp, 1'b0);
        check("idle_after", busy, 1'b0);
    endtask

    // Read that the buffer build answers without a bus cycle.
    task automatic hit_or_bus(input logic [15:0] addr, input logic [127:0] line,
                              input logic [15:0] exp_word);
`ifdef WB_LINE_PORT_RDBUF_EN
        sb.push_back({1'b0, exp_word});
        @(negedge clk);
        req_read = 1'b1; req_addr = addr;
        @(posedge clk);
        @(negedge clk);
        check("hit_resp", resp, 1'b1);
        check("hit_no_stb", wb_stb, 1'b0);
        req_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("hit_resp_one_cycle", resp, 1'b0);
        check("hit_idle", busy, 1'b0);
`else
        run_txn(1'b1, 1'b0, addr, 16'h0000, 2'b00, line, 1, 1'b1, 1'b0,
                1'b0, exp_word, addr[15:4], 1'b0, 16'hFFFF);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req_read = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        wb_dat_s = '0; wb_ack = 1'b0; wb_err = 1'b0;
        @(negedge clk);
        check("rst_stb", wb_stb, 1'b0);
        check("rst_cyc", wb_cyc, 1'b0);
        check("rst_we", wb_we, 1'b0);
        check("rst_sel", wb_sel, 16'h0000);
        check("rst_adr", wb_adr, 12'h000);
        check("rst_dat_m", wb_dat_m, 128'h0);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_resp", {resp, resp_err}, 2'b00);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        // Read, ack in first bus cycle.
        run_txn(1'b1, 1'b0, 16'h1236, 16'h0000, 2'b00, L1, 1, 1'b1, 1'b0,
                1'b0, 16'hBEEF, 12'h123, 1'b0, 16'hFFFF);
        // Write low byte of word 2, ack after two strobe cycles.
        run_txn(1'b0, 1'b1, 16'h0A04, 16'h55AA, 2'b01, L1, 2, 1'b1, 1'b0,
                1'b0, 16'h2222, 12'h0A0, 1'b1, 16'h0010);
        // No termination: timeout after four strobe cycles.
        run_txn(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, L1, 4, 1'b0, 1'b0,
                1'b1, 16'h0000, 12'h004, 1'b0, 16'hFFFF);
        // Read and write together: write issued; ack beats err.
        run_txn(1'b1, 1'b1, 16'h0002, 16'h1234, 2'b11, L1, 1, 1'b1, 1'b1,
                1'b0, 16'h1111, 12'h000, 1'b1, 16'h000C);
        // Read with bus error.
        run_txn(1'b1, 1'b0, 16'h0A0E, 16'h0000, 2'b00, L1, 3, 1'b0, 1'b1,
                1'b1, 16'h7777, 12'h0A0, 1'b0, 16'hFFFF);
        // Write with no byte enables still runs a bus cycle.
        run_txn(1'b0, 1'b1, 16'h0100, 16'hFFFF, 2'b00, L1, 1, 1'b1, 1'b0,
                1'b0, 16'h0000, 12'h010, 1'b1, 16'h0000);

        // Reset while the strobe is up: drops at once, no resp.
        @(negedge clk);
        req_read = 1'b1; req_addr = 16'h1000;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_stb", wb_stb, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_stb", wb_stb, 1'b0);
        check("rst_async_busy", busy, 1'b0);
        @(negedge clk);
        req_read = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_resp", resp, 1'b0);
        end
        run_txn(1'b1, 1'b0, 16'h1236, 16'h0000, 2'b00, L1, 1, 1'b1, 1'b0,
                1'b0, 16'hBEEF, 12'h123, 1'b0, 16'hFFFF);

        // Line buffer: fill, hit, write merge, write-error invalidate.
        run_txn(1'b1, 1'b0, 16'h2000, 16'h0000, 2'b00, L2, 1, 1'b1, 1'b0,
                1'b0, 16'h0000, 12'h200, 1'b0, 16'hFFFF);
        hit_or_bus(16'h200E, L2, 16'h7077);
        run_txn(1'b0, 1'b1, 16'h2004, 16'hA5C3, 2'b10, L2, 1, 1'b1, 1'b0,
                1'b0, 16'h2022, 12'h200, 1'b1, 16'h0020);
        hit_or_bus(16'h2004, L2M, 16'hA522);
        run_txn(1'b0, 1'b1, 16'h2008, 16'h1111, 2'b11, L2, 1, 1'b0, 1'b1,
                1'b1, 16'h4044, 12'h200, 1'b1, 16'h0300);
        run_txn(1'b1, 1'b0, 16'h2002, 16'h0000, 2'b00, L3, 1, 1'b1, 1'b0,
                1'b0, 16'hC0DE, 12'h200, 1'b0, 16'hFFFF);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
